grf_write_scheduler: RTL and testbench
======================================

Name: grf_write_scheduler

Overview:
Shares the single general register file write port between two producers:
- the pipeline writeback stage (WB), which cannot stall;
- the multi-cycle multiply/divide unit (MD), which is back-pressurable.

MD results are buffered in a small in-order queue and drained in cycles when WB does not write. The block also exports a pending-write mask and a starvation stall request to the hazard unit. It sits between WB/MD and the register file write port.

Parameters:
- DEPTH, 4, MD queue entries; power of two, >= 2.
- STARVE_LIMIT, 8, consecutive cycles a queued MD head may lose to WB before stallRequest asserts; >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wbValid  in  1  WB has a result this cycle.
- wbAddress  in  5  WB destination register.
- wbData  in  32  WB result.
- wbPC  in  32  PC of the WB instruction.
- mdValid  in  1  MD offers a result.
- mdReady  out  1  queue can accept an MD result.
- mdAddress  in  5  MD destination register.
- mdData  in  32  MD result.
- mdPC  in  32  PC of the MD instruction.
- writeAddress  out  5  to register file; 0 means no write.
- writeData  out  32  to register file.
- debugPC  out  32  to register file.
- pendingMask  out  32  bit r set iff any valid queue entry targets register r.
- stallRequest  out  1  asks the pipeline to suppress WB writes so the queue can drain.

Behaviour:
- Reset (reset=0, asynchronous):
  - queue empty: count=0, head/tail pointers=0;
  - starvation counter=0; stallRequest=0; pendingMask=0;
  - mdReady=1 once reset is released.
  - Reset asserted mid-operation discards all queued entries; none are written.
- Write port outputs are combinational from the current inputs and the queue head. The register file commits them on the same clk edge, so write latency is 0 cycles from grant.
- Grant, each cycle:
  - wbValid=1 and wbAddress!=0: WB granted; writeAddress/writeData/debugPC = wbAddress/wbData/wbPC.
  - otherwise, queue non-empty: head granted; outputs = head fields; head is popped at the edge.
  - otherwise: writeAddress=0, writeData=0, debugPC=0.
  - wbValid=1 with wbAddress=0 counts as "no WB write", so the queue may drain that cycle.
- MD handshake:
  - mdReady = (count < DEPTH), computed from registered count only; a same-cycle pop does not raise mdReady.
  - Push occurs at the edge when mdValid && mdReady.
  - A push with mdAddress=0 is accepted (handshake completes) but not enqueued.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Queue order is strict FIFO.
- pendingMask:
  - OR of one-hot(address) over valid entries; duplicate addresses allowed.
  - Reflects registered state; a same-cycle push is not visible until the next cycle.
- Starvation counter:
  - Increments each cycle the queue is non-empty and WB is granted.
  - Clears when the head is granted or the queue is empty.
  - Saturates at STARVE_LIMIT.
  - stallRequest = (counter == STARVE_LIMIT), registered.
  - stallRequest stays 1 until a pop occurs; it deasserts the cycle after the pop.
- WAW rule: the hazard unit uses pendingMask to keep WB from writing a register with a queued write. If a WB write targets a pending register anyway:
  - the block still grants WB;
  - the queued value later overwrites it. This ordering is defined behaviour, not an error.
- Widths: all data passes through unmodified; no arithmetic on data.

Optional Feature:
GRF_SCHED_TRACE_EN:
- Defined: on each rising edge with writeAddress!=0, $display prints the time, debugPC, writeAddress, writeData and the source tag ("WB" or "MD"). On each edge where stallRequest rises, it prints a "starve" line with the head PC.
- Undefined: no $display statements, no tag logic; port behaviour is identical either way.

Test Plan:
- Reset: hold reset=0 with random inputs -> writeAddress=0, mdReady=1 after release, pendingMask=0, stallRequest=0; assert reset while 3 entries are queued -> queue empties immediately, no queued write ever appears.
- Idle drain: wbValid=0; push MD $5=0x11111111 (PC 0x3000) -> same edge count=1, pendingMask=0x20; next cycle writeAddress=5, writeData=0x11111111, debugPC=0x3000; then pendingMask=0.
- Priority and fill: wbValid=1 with wbAddress cycling 8..15; push MD to $1..$4 -> mdReady=0 after 4 pushes, pendingMask=0x1E; a 5th mdValid is held unaccepted; drop wbValid -> $1,$2,$3,$4 written in order over 4 cycles.
- Starvation: one MD entry queued, wbValid=1/wbAddress=9 every cycle -> stallRequest=1 after 8 WB grants; drop wbValid -> head written that cycle, stallRequest=0 next cycle.
- Zero-address cases: MD push to $0 -> accepted, count stays 0; wbValid=1/wbAddress=0 with a queued entry -> queued entry granted that cycle.
- Simultaneous push/pop at count=DEPTH-1 with WB idle -> count stays DEPTH-1, mdReady stays 1, FIFO order preserved across pointer wrap (run 3*DEPTH entries, check the write sequence).

Source files
------------

// File: rtl/grf_write_scheduler.sv
// Shares the GRF write port between the WB stage (priority, never stalls) and a queued MD unit.
// Optional trace output: define GRF_SCHED_TRACE_EN.
module grf_write_scheduler #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbValid,
  input  logic [4:0]  wbAddress,
  input  logic [31:0] wbData,
  input  logic [31:0] wbPC,
  input  logic        mdValid,
  output logic        mdReady,
  input  logic [4:0]  mdAddress,
  input  logic [31:0] mdData,
  input  logic [31:0] mdPC,
  output logic [4:0]  writeAddress,
  output logic [31:0] writeData,
  output logic [31:0] debugPC,
  output logic [31:0] pendingMask,
  output logic        stallRequest
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [SW-1:0] LP_LIMIT = SW'(STARVE_LIMIT);

  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [31:0]      r_pc   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;
  logic             r_stall;

  logic             w_nonempty;
  logic             w_wb_gnt;
  logic             w_md_gnt;
  logic             w_push;
  logic [CW-1:0]    w_count_nxt;
  logic [SW-1:0]    w_starve_nxt;
  logic             w_stall_nxt;
  logic [31:0]      w_mask;

  assign w_nonempty = (r_count != '0);
  assign w_wb_gnt   = reset && wbValid && (wbAddress != 5'd0);
  assign w_md_gnt   = reset && !w_wb_gnt && w_nonempty;
  assign mdReady    = reset && (r_count < LP_DEPTH);
  // Address-0 results complete the handshake but never occupy a slot.
  assign w_push     = mdValid && mdReady && (mdAddress != 5'd0);

  always_comb begin
    writeAddress = '0;
    writeData    = '0;
    debugPC      = '0;
    if (w_wb_gnt) begin
      writeAddress = wbAddress;
      writeData    = wbData;
      debugPC      = wbPC;
    end else if (w_md_gnt) begin
      writeAddress = r_addr[r_head];
      writeData    = r_data[r_head];
      debugPC      = r_pc[r_head];
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_md_gnt})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (!w_nonempty || w_md_gnt) begin
      w_starve_nxt = '0;
    end else if (r_starve != LP_LIMIT) begin
      w_starve_nxt = r_starve + SW'(1);
    end
  end

  assign w_stall_nxt = (w_starve_nxt == LP_LIMIT);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_mask[r_addr[i]] = 1'b1;
    end
  end

  assign pendingMask  = w_mask;
  assign stallRequest = r_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld    <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else begin
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      r_stall  <= w_stall_nxt;
      // Head and tail never alias while both move: a push needs count < DEPTH, a pop needs count > 0.
      if (w_md_gnt) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + AW'(1);
      end
      if (w_push) begin
        r_vld[r_tail]  <= 1'b1;
        r_addr[r_tail] <= mdAddress;
        r_data[r_tail] <= mdData;
        r_pc[r_tail]   <= mdPC;
        r_tail         <= r_tail + AW'(1);
      end
    end
  end

`ifdef GRF_SCHED_TRACE_EN
  always_ff @(posedge clk) begin
    if (writeAddress != 5'd0)
      $display("%0t pc=%h rd=%0d data=%h %s", $time, debugPC, writeAddress, writeData,
               w_wb_gnt ? "WB" : "MD");
    if (reset && w_stall_nxt && !r_stall)
      $display("%0t starve head pc=%h", $time, r_pc[r_head]);
  end
`endif

endmodule

// File: tb/tb_grf_write_scheduler.sv
// Directed bench for grf_write_scheduler (DEPTH=4, STARVE_LIMIT=8).
module tb_grf_write_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        wbValid;
  logic [4:0]  wbAddress;
  logic [31:0] wbData;
  logic [31:0] wbPC;
  logic        mdValid;
  logic        mdReady;
  logic [4:0]  mdAddress;
  logic [31:0] mdData;
  logic [31:0] mdPC;
  logic [4:0]  writeAddress;
  logic [31:0] writeData;
  logic [31:0] debugPC;
  logic [31:0] pendingMask;
  logic        stallRequest;

  int total = 0;
  int bad   = 0;

  grf_write_scheduler #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .wbValid(wbValid), .wbAddress(wbAddress), .wbData(wbData), .wbPC(wbPC),
    .mdValid(mdValid), .mdReady(mdReady), .mdAddress(mdAddress), .mdData(mdData), .mdPC(mdPC),
    .writeAddress(writeAddress), .writeData(writeData), .debugPC(debugPC),
    .pendingMask(pendingMask), .stallRequest(stallRequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wb(input logic v, input logic [4:0] a);
    wbValid   = v;
    wbAddress = a;
    wbData    = 32'hD000_0000 | 32'(a);
    wbPC      = 32'h0000_0100 + 32'(a) * 4;
  endtask

  task automatic md(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    mdValid   = v;
    mdAddress = a;
    mdData    = d;
    mdPC      = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb(1'($urandom), 5'($urandom));
      md(1'($urandom), 5'($urandom), $urandom, $urandom);
      settle();
      chk("rst_waddr", 32'(writeAddress), 32'd0);
      tick();
      chk("rst_mask", pendingMask, 32'd0);
      chk("rst_stall", 32'(stallRequest), 32'd0);
    end
    wb(1'b0, 5'd0);
    md(1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    reset = 1'b1;
    settle();
    chk("rel_mdready", 32'(mdReady), 32'd1);
    chk("rel_waddr", 32'(writeAddress), 32'd0);
    chk("rel_mask", pendingMask, 32'd0);
    tick();

    // Idle drain
    md(1'b1, 5'd5, 32'h1111_1111, 32'h0000_3000);
    settle();
    chk("idle_pre_waddr", 32'(writeAddress), 32'd0);
    chk("idle_pre_mask", pendingMask, 32'd0);
    tick();
    md(1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("idle_mask", pendingMask, 32'h0000_0020);
    chk("idle_waddr", 32'(writeAddress), 32'd5);
    chk("idle_wdata", writeData, 32'h1111_1111);
    chk("idle_pc", debugPC, 32'h0000_3000);
    tick();
    chk("idle_mask_after", pendingMask, 32'd0);
    chk("idle_waddr_after", 32'(writeAddress), 32'd0);

    // Priority and fill: WB owns the port while MD fills the queue
    for (int k = 1; k <= 4; k++) begin
      wb(1'b1, 5'(7 + k));
      md(1'b1, 5'(k), 32'h0000_00A0 + 32'(k), 32'h0000_4000 + 32'(k) * 4);
      settle();
      chk("fill_mdready", 32'(mdReady), 32'd1);
      chk("fill_waddr", 32'(writeAddress), 32'(7 + k));
      chk("fill_wdata", writeData, 32'hD000_0000 | 32'(7 + k));
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      wb(1'b1, 5'(12 + k));
      md(1'b1, 5'd6, 32'h0000_0BAD, 32'h0000_4FFC);
      settle();
      chk("full_mdready", 32'(mdReady), 32'd0);
      chk("full_mask", pendingMask, 32'h0000_001E);
      chk("full_waddr", 32'(writeAddress), 32'(12 + k));
      tick();
    end
    wb(1'b0, 5'd0);
    md(1'b0, 5'd0, 32'd0, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk("drain_waddr", 32'(writeAddress), 32'(k));
      chk("drain_wdata", writeData, 32'h0000_00A0 + 32'(k));
      chk("drain_pc", debugPC, 32'h0000_4000 + 32'(k) * 4);
      tick();
    end
    chk("drain_mask", pendingMask, 32'd0);
    chk("drain_waddr_idle", 32'(writeAddress), 32'd0);

    // Starvation
    wb(1'b1, 5'd9);
    md(1'b1, 5'd7, 32'h0000_0077, 32'h0000_5000);
    tick();
    md(1'b0, 5'd0, 32'd0, 32'd0);
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("starve_pre_stall", 32'(stallRequest), 32'd0);
      chk("starve_waddr", 32'(writeAddress), 32'd9);
      tick();
    end
    chk("starve_stall", 32'(stallRequest), 32'd1);
    chk("starve_mask", pendingMask, 32'h0000_0080);
    tick();
    tick();
    chk("starve_sat_stall", 32'(stallRequest), 32'd1);
    wb(1'b0, 5'd0);
    settle();
    chk("starve_head_waddr", 32'(writeAddress), 32'd7);
    chk("starve_head_wdata", writeData, 32'h0000_0077);
    chk("starve_head_pc", debugPC, 32'h0000_5000);
    chk("starve_same_cycle_stall", 32'(stallRequest), 32'd1);
    tick();
    chk("starve_release", 32'(stallRequest), 32'd0);
    chk("starve_mask_after", pendingMask, 32'd0);

    // Zero-address cases
    for (int k = 0; k < 5; k++) begin
      md(1'b1, 5'd0, 32'hDEAD_0000 + 32'(k), 32'h0000_6FF0);
      settle();
      chk("zero_md_ready", 32'(mdReady), 32'd1);
      tick();
    end
    md(1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("zero_md_mask", pendingMask, 32'd0);
    chk("zero_md_waddr", 32'(writeAddress), 32'd0);
    wb(1'b1, 5'd12);
    md(1'b1, 5'd3, 32'h0000_0033, 32'h0000_6000);
    tick();
    md(1'b0, 5'd0, 32'd0, 32'd0);
    wb(1'b1, 5'd0);
    settle();
    chk("zero_wb_waddr", 32'(writeAddress), 32'd3);
    chk("zero_wb_wdata", writeData, 32'h0000_0033);
    tick();
    chk("zero_wb_idle", 32'(writeAddress), 32'd0);
    chk("zero_wb_mask", pendingMask, 32'd0);

    // Simultaneous push/pop at count=DEPTH-1, across several pointer wraps
    for (int k = 0; k < 3; k++) begin
      wb(1'b1, 5'd8);
      md(1'b1, 5'(k + 1), 32'hC000_0000 + 32'(k), 32'h0000_7000 + 32'(k) * 4);
      tick();
    end
    wb(1'b0, 5'd0);
    md(1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("stream_mask", pendingMask, 32'h0000_000E);
    for (int j = 0; j < 12; j++) begin
      if (j + 3 < 12)
        md(1'b1, 5'(j + 4), 32'hC000_0000 + 32'(j + 3), 32'h0000_7000 + 32'(j + 3) * 4);
      else
        md(1'b0, 5'd0, 32'd0, 32'd0);
      settle();
      chk("stream_mdready", 32'(mdReady), 32'd1);
      chk("stream_waddr", 32'(writeAddress), 32'(j + 1));
      chk("stream_wdata", writeData, 32'hC000_0000 + 32'(j));
      chk("stream_pc", debugPC, 32'h0000_7000 + 32'(j) * 4);
      tick();
    end
    chk("stream_end_waddr", 32'(writeAddress), 32'd0);
    chk("stream_end_mask", pendingMask, 32'd0);

    // Reset mid-operation discards queued entries
    for (int k = 0; k < 3; k++) begin
      wb(1'b1, 5'd8);
      md(1'b1, 5'(20 + k), 32'hE000_0000 + 32'(k), 32'h0000_8000);
      tick();
    end
    md(1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("mid_mask_before", pendingMask, 32'h0070_0000);
    reset = 1'b0;
    settle();
    chk("mid_mask_reset", pendingMask, 32'd0);
    chk("mid_waddr_reset", 32'(writeAddress), 32'd0);
    wb(1'b0, 5'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("mid_no_write", 32'(writeAddress), 32'd0);
      chk("mid_mask_after", pendingMask, 32'd0);
      tick();
    end
    chk("mid_mdready", 32'(mdReady), 32'd1);
    chk("mid_stall", 32'(stallRequest), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
